// File: rtl/exec_core_if.sv
// exec_core_if: byte-wide I/O channel between the execution core and its
// devices.
//   tx_data/tx_valid/tx_ready : output stream, core -> sink (valid/ready)
//   rx_data/rx_valid/rx_ready : input stream, source -> core (valid/ready)
// The master modport is the core side. The slave modport is the device side.
interface exec_core_if #(
    parameter int DWIDTH = 8
);
    logic [DWIDTH-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DWIDTH-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/exec_core.sv
// exec_core: parameterised multi-cycle execution core.
// The core sequences FETCH -> EXEC -> (WAIT_TX | WAIT_RX) -> FETCH. A HALT
// instruction moves the core into the absorbing HALTED state.
// Each instruction can be gated by a condition on the registered flags. A
// skipped instruction changes no register, flag or I/O state. It still
// advances pc and still pulses retired.
// Ports:
//   system_clk  : clock. All state changes on the rising edge.
//   MR          : asynchronous active-high reset.
//   pc          : program address to the external ROM.
//   instr       : ROM data = {op[2:0], cond[2:0], rd, rs, imm}.
//   phase_exec  : high while the core is in EXEC.
//   io          : tx/rx valid-ready channel (master side).
//   flags_czno  : registered {C,Z,N,O}.
//   retired     : one-cycle pulse in the FETCH cycle after an instruction
//                 completes.
//   halted      : high while the core is in HALTED.
//   halt_code   : R[rs], captured by HALT.
module exec_core #(
    parameter  int DWIDTH = 8,
    parameter  int AWIDTH = 16,
    parameter  int NREGS  = 4,
    localparam int RW     = $clog2(NREGS),
    localparam int IWIDTH = 6 + 2*RW + DWIDTH
) (
    input  logic               system_clk,
    input  logic               MR,
    output logic [AWIDTH-1:0]  pc,
    input  logic [IWIDTH-1:0]  instr,
    output logic               phase_exec,
    exec_core_if.master        io,
    output logic [3:0]         flags_czno,
    output logic               retired,
    output logic               halted,
    output logic [DWIDTH-1:0]  halt_code
);

    typedef enum logic [2:0] {
        S_FETCH, S_EXEC, S_WAIT_TX, S_WAIT_RX, S_HALTED
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDI  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_OUT  = 3'd4;
    localparam logic [2:0] OP_IN   = 3'd5;
    localparam logic [2:0] OP_JMP  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    state_t                        state_q, state_d;
    logic [AWIDTH-1:0]             pc_q, pc_d, pc_inc, jmp_tgt;
    logic [IWIDTH-1:0]             ir_q, ir_d;
    logic [3:0]                    flags_q, flags_d;
    logic                          retired_q, retired_d;
    logic [DWIDTH-1:0]             tx_data_q, tx_data_d;
    logic [DWIDTH-1:0]             halt_code_q, halt_code_d;
    logic [NREGS-1:0][DWIDTH-1:0]  rf_q;

    logic                          wr_en;
    logic [RW-1:0]                 wr_idx;
    logic [DWIDTH-1:0]             wr_data;

    // Instruction fields decoded from the IR latched in FETCH.
    logic [2:0]         op, cnd;
    logic [RW-1:0]      rd, rs;
    logic [DWIDTH-1:0]  imm, a, b;
    assign {op, cnd, rd, rs, imm} = ir_q;
    assign a = rf_q[rd];
    assign b = rf_q[rs];

    assign pc_inc = pc_q + AWIDTH'(1);

    // Jump target is the low AWIDTH bits of {R[rs], imm}.
    logic [2*DWIDTH-1:0] jcat;
    assign jcat    = {b, imm};
    assign jmp_tgt = jcat[AWIDTH-1:0];

    // Condition codes are evaluated against the flags held at EXEC entry.
    logic cond_ok;
    always_comb begin
        cond_ok = 1'b0;
        case (cnd)
            3'd0:    cond_ok = 1'b1;
            3'd1:    cond_ok = flags_q[3];
            3'd2:    cond_ok = flags_q[2];
            3'd3:    cond_ok = flags_q[1];
            3'd4:    cond_ok = flags_q[0];
            3'd5:    cond_ok = !flags_q[3];
            3'd6:    cond_ok = !flags_q[2];
            default: cond_ok = 1'b0;
        endcase
    end

    // ALU. The subtract carry is the borrow, which is set when rd < rs unsigned.
    logic [DWIDTH:0]    sum, dif;
    logic [DWIDTH-1:0]  alu_res;
    logic               alu_c, alu_o;
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        dif     = {1'b0, a} - {1'b0, b};
        alu_res = sum[DWIDTH-1:0];
        alu_c   = sum[DWIDTH];
        alu_o   = (a[DWIDTH-1] == b[DWIDTH-1]) && (alu_res[DWIDTH-1] != a[DWIDTH-1]);
        if (op == OP_SUB) begin
            alu_res = dif[DWIDTH-1:0];
            alu_c   = dif[DWIDTH];
            alu_o   = (a[DWIDTH-1] != b[DWIDTH-1]) && (alu_res[DWIDTH-1] != a[DWIDTH-1]);
        end
    end

    // Next-state logic and datapath control.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        flags_d     = flags_q;
        retired_d   = 1'b0;
        tx_data_d   = tx_data_q;
        halt_code_d = halt_code_q;
        wr_en       = 1'b0;
        wr_idx      = rd;
        wr_data     = '0;

        case (state_q)
            S_FETCH: begin
                ir_d    = instr;
                state_d = S_EXEC;
            end

            S_EXEC: begin
                if (!cond_ok) begin
                    pc_d      = pc_inc;
                    retired_d = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    case (op)
                        OP_LDI: begin
                            wr_en     = 1'b1;
                            wr_data   = imm;
                            pc_d      = pc_inc;
                            retired_d = 1'b1;
                            state_d   = S_FETCH;
                        end
                        OP_ADD, OP_SUB: begin
                            wr_en     = 1'b1;
                            wr_data   = alu_res;
                            flags_d   = {alu_c, (alu_res == '0), alu_res[DWIDTH-1], alu_o};
                            pc_d      = pc_inc;
                            retired_d = 1'b1;
                            state_d   = S_FETCH;
                        end
                        OP_OUT: begin
                            // Capture the data now so that it stays stable for the whole wait.
                            tx_data_d = b;
                            state_d   = S_WAIT_TX;
                        end
                        OP_IN: begin
                            state_d = S_WAIT_RX;
                        end
                        OP_JMP: begin
                            pc_d      = jmp_tgt;
                            retired_d = 1'b1;
                            state_d   = S_FETCH;
                        end
                        OP_HALT: begin
                            halt_code_d = b;
                            pc_d        = pc_inc;
                            state_d     = S_HALTED;
                        end
                        default: begin // OP_NOP
                            pc_d      = pc_inc;
                            retired_d = 1'b1;
                            state_d   = S_FETCH;
                        end
                    endcase
                end
            end

            S_WAIT_TX: begin
                // tx_valid is high throughout this state, so any tx_ready here completes the transfer.
                if (io.tx_ready) begin
                    pc_d      = pc_inc;
                    retired_d = 1'b1;
                    state_d   = S_FETCH;
                end
            end

            S_WAIT_RX: begin
                if (io.rx_valid) begin
                    wr_en     = 1'b1;
                    wr_data   = io.rx_data;
                    pc_d      = pc_inc;
                    retired_d = 1'b1;
                    state_d   = S_FETCH;
                end
            end

            S_HALTED: begin
                state_d = S_HALTED;
            end

            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge system_clk or posedge MR) begin
        if (MR) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            flags_q     <= '0;
            retired_q   <= 1'b0;
            tx_data_q   <= '0;
            halt_code_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            flags_q     <= flags_d;
            retired_q   <= retired_d;
            tx_data_q   <= tx_data_d;
            halt_code_q <= halt_code_d;
        end
    end

    always_ff @(posedge system_clk or posedge MR) begin
        if (MR) begin
            rf_q <= '0;
        end else if (wr_en) begin
            rf_q[wr_idx] <= wr_data;
        end
    end

    // The handshake outputs decode directly from the state register.
    // Reset therefore clears them at once, even in the middle of a transfer.
    assign pc          = pc_q;
    assign phase_exec  = (state_q == S_EXEC);
    assign io.tx_valid = (state_q == S_WAIT_TX);
    assign io.tx_data  = tx_data_q;
    assign io.rx_ready = (state_q == S_WAIT_RX);
    assign flags_czno  = flags_q;
    assign retired     = retired_q;
    assign halted      = (state_q == S_HALTED);
    assign halt_code   = halt_code_q;

`ifndef SYNTHESIS
    // An unknown ROM word would silently corrupt the IR, so the simulation stops on it.
    always @(posedge system_clk) begin
        if (!MR && state_q == S_FETCH && $isunknown(instr)) begin
            $error("exec_core: unknown instr at pc %0h", pc_q);
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_exec_core.sv
// tb_exec_core: directed bench for exec_core (DWIDTH=8, AWIDTH=16, NREGS=4).
// A small ROM array drives instr from pc. Register contents are observed
// through OUT instructions.
module tb_exec_core;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int NR = 4;
    localparam int IW = 6 + 2*$clog2(NR) + DW;

    logic           clk = 1'b0;
    logic           mr;
    logic [AW-1:0]  pc;
    logic [IW-1:0]  instr;
    logic           phase_exec, retired, halted;
    logic [3:0]     flags;
    logic [DW-1:0]  halt_code;
    logic [IW-1:0]  rom [256];

    int total = 0;
    int bad   = 0;

    exec_core_if #(.DWIDTH(DW)) io ();

    exec_core #(.DWIDTH(DW), .AWIDTH(AW), .NREGS(NR)) dut (
        .system_clk (clk),
        .MR         (mr),
        .pc         (pc),
        .instr      (instr),
        .phase_exec (phase_exec),
        .io         (io.master),
        .flags_czno (flags),
        .retired    (retired),
        .halted     (halted),
        .halt_code  (halt_code)
    );

    always #5 clk = ~clk;
    assign instr = rom[pc[7:0]];

    function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic [2:0] cnd,
                                         input logic [1:0] rd, input logic [1:0] rs,
                                         input logic [7:0] imm);
        return {op, cnd, rd, rs, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tx(input string tag);
        int n = 0;
        while (io.tx_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_txwait"}, io.tx_valid, 1);
    endtask

    // Wait for an OUT, check the data, flags and pc, then accept the byte at once.
    task automatic do_out(input string tag, input logic [7:0] d, input logic [3:0] f,
                          input logic [15:0] p);
        wait_tx(tag);
        chk({tag, "_data"}, io.tx_data, d);
        chk({tag, "_flags"}, flags, f);
        chk({tag, "_pc"}, pc, p);
        io.tx_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_txdrop"}, io.tx_valid, 0);
        chk({tag, "_retired"}, retired, 1);
        io.tx_ready = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rom[0]  = mk(3'd1, 3'd0, 2'd0, 2'd0, 8'h7F); // LDI R0,7F
        rom[1]  = mk(3'd1, 3'd0, 2'd1, 2'd0, 8'h01); // LDI R1,01
        rom[2]  = mk(3'd2, 3'd0, 2'd0, 2'd1, 8'h00); // ADD R0,R1
        rom[3]  = mk(3'd4, 3'd0, 2'd0, 2'd0, 8'h00); // OUT R0
        rom[4]  = mk(3'd3, 3'd0, 2'd1, 2'd1, 8'h00); // SUB R1,R1
        rom[5]  = mk(3'd2, 3'd6, 2'd0, 2'd0, 8'h00); // !Z ADD R0,R0 (skipped)
        rom[6]  = mk(3'd6, 3'd2, 2'd0, 2'd1, 8'h10); // Z JMP R1:10
        rom[16] = mk(3'd4, 3'd0, 2'd0, 2'd0, 8'h00); // OUT R0
        rom[17] = mk(3'd1, 3'd0, 2'd2, 2'd0, 8'h00); // LDI R2,00
        rom[18] = mk(3'd1, 3'd0, 2'd3, 2'd0, 8'h01); // LDI R3,01
        rom[19] = mk(3'd3, 3'd0, 2'd2, 2'd3, 8'h00); // SUB R2,R3
        rom[20] = mk(3'd4, 3'd0, 2'd0, 2'd2, 8'h00); // OUT R2
        rom[21] = mk(3'd1, 3'd7, 2'd2, 2'd0, 8'h00); // never LDI R2,00
        rom[22] = mk(3'd4, 3'd0, 2'd0, 2'd2, 8'h00); // OUT R2
        rom[23] = mk(3'd1, 3'd0, 2'd0, 2'd0, 8'h41); // LDI R0,41
        rom[24] = mk(3'd4, 3'd0, 2'd0, 2'd0, 8'h00); // OUT R0 (stalled)
        rom[25] = mk(3'd5, 3'd0, 2'd3, 2'd0, 8'h00); // IN R3
        rom[26] = mk(3'd4, 3'd0, 2'd0, 2'd3, 8'h00); // OUT R3
        rom[27] = mk(3'd1, 3'd0, 2'd2, 2'd0, 8'h2A); // LDI R2,2A
        rom[28] = mk(3'd7, 3'd0, 2'd0, 2'd2, 8'h00); // HALT R2

        mr = 1'b1;
        io.tx_ready = 1'b0;
        io.rx_valid = 1'b0;
        io.rx_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_flags", flags, 0);
        chk("rst_hs", {io.tx_valid, io.rx_ready, retired, halted, phase_exec}, 0);
        chk("rst_code", halt_code, 0);

        mr = 1'b0;
        @(negedge clk);
        chk("first_exec", phase_exec, 1);
        chk("first_pc", pc, 0);

        do_out("add", 8'h80, 4'b0011, 16'd3);
        do_out("skipjmp", 8'h80, 4'b0100, 16'h0010);
        do_out("sub", 8'hFF, 4'b1010, 16'd20);
        do_out("never", 8'hFF, 4'b1010, 16'd22);

        // Stalled OUT. rx_valid toggles outside WAIT_RX and must be ignored.
        wait_tx("stall");
        io.rx_valid = 1'b1;
        io.rx_data  = 8'h77;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", io.tx_valid, 1);
            chk("stall_data", io.tx_data, 8'h41);
            chk("stall_pc", pc, 24);
            @(negedge clk);
        end
        io.rx_valid = 1'b0;
        io.tx_ready = 1'b1;
        @(negedge clk);
        io.tx_ready = 1'b0;
        chk("stall_drop", io.tx_valid, 0);
        chk("stall_ret", retired, 1);
        chk("stall_nextpc", pc, 25);

        // IN with rx_valid arriving after three cycles.
        n = 0;
        while (io.rx_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("rx_wait", io.rx_ready, 1);
        for (int i = 0; i < 3; i++) begin
            chk("rx_hold", io.rx_ready, 1);
            chk("rx_pc", pc, 25);
            @(negedge clk);
        end
        io.rx_data  = 8'h5A;
        io.rx_valid = 1'b1;
        @(negedge clk);
        io.rx_valid = 1'b0;
        io.rx_data  = '0;
        chk("rx_drop", io.rx_ready, 0);
        chk("rx_ret", retired, 1);
        do_out("in", 8'h5A, 4'b1010, 16'd26);

        // HALT
        n = 0;
        while (halted !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("halt", halted, 1);
        chk("halt_code", halt_code, 8'h2A);
        chk("halt_pc", pc, 29);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_frozen", pc, 29);
            chk("halt_noret", retired, 0);
            chk("halt_stay", halted, 1);
        end
        mr = 1'b1;
        #1;
        chk("mr_halted", halted, 0);
        chk("mr_pc", pc, 0);
        chk("mr_flags", flags, 0);
        chk("mr_code", halt_code, 0);

        // pc wrap: jump to FFFF, where the ROM holds a NOP.
        rom[0] = mk(3'd1, 3'd0, 2'd1, 2'd0, 8'hFF); // LDI R1,FF
        rom[1] = mk(3'd6, 3'd0, 2'd0, 2'd1, 8'hFF); // JMP R1:FF
        @(negedge clk);
        mr = 1'b0;
        n = 0;
        while (pc !== 16'hFFFF && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_reach", pc, 16'hFFFF);
        chk("wrap_ret0", retired, 1);
        @(negedge clk);
        chk("wrap_exec", phase_exec, 1);
        chk("wrap_ret1", retired, 0);
        @(negedge clk);
        chk("wrap_pc", pc, 0);
        chk("wrap_ret2", retired, 1);

        // Reset in the middle of a transfer drops the handshake at once.
        mr = 1'b1;
        rom[0] = mk(3'd4, 3'd0, 2'd0, 2'd0, 8'h00); // OUT R0
        @(negedge clk);
        mr = 1'b0;
        wait_tx("mrtx");
        chk("mrtx_data", io.tx_data, 0);
        mr = 1'b1;
        #1;
        chk("mrtx_drop", io.tx_valid, 0);
        chk("mrtx_pc", pc, 0);

        rom[0] = mk(3'd5, 3'd0, 2'd0, 2'd0, 8'h00); // IN R0
        @(negedge clk);
        mr = 1'b0;
        n = 0;
        while (io.rx_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("mrrx_wait", io.rx_ready, 1);
        mr = 1'b1;
        #1;
        chk("mrrx_drop", io.rx_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exec_core.md
Name: exec_core

Overview:
- Parametrised successor to the fixed 8-bit two-phase CPU top: a self-contained execution core with configurable data width, address width and register count.
- Explicit fetch/exec/wait/halt sequencing replaces the phase-clock gating.
- The core adds condition-gated execution: a skipped instruction writes neither flags nor registers, closing the known flag-update defect.
- Blocking valid/ready handshakes replace the UART TXE/RXF strobes.
- It drives an external program ROM via pc/instr and sits between the ROM and the I/O devices.

Parameters:
- DWIDTH, 8, data/register/immediate width (≥4).
- AWIDTH, 16, program counter width (≤2*DWIDTH).
- NREGS, 4, number of general registers (power of 2, ≥2).
- RW (local), $clog2(NREGS), register index width.
- IWIDTH (local), 6+2*RW+DWIDTH, instruction width.

Ports:
- system_clk  in  1  single clock; all state on rising edge
- MR  in  1  asynchronous active-high reset
- pc  out  AWIDTH  program address to ROM
- instr  in  IWIDTH  ROM data = {op[2:0], cond[2:0], rd[RW], rs[RW], imm[DWIDTH]}
- phase_exec  out  1  high while in EXEC
- tx_data  out  DWIDTH  output byte
- tx_valid  out  1  output request
- tx_ready  in  1  sink accepts
- rx_data  in  DWIDTH  input byte
- rx_valid  in  1  source has data
- rx_ready  out  1  core takes data
- flags_czno  out  4  registered {C,Z,N,O}
- retired  out  1  one-cycle pulse when an instruction completes (including skipped ones)
- halted  out  1  core stopped
- halt_code  out  DWIDTH  R[rs] captured at HALT

Behaviour:
Reset (async while MR=1):
- pc=0, all R=0, flags=0, state=FETCH.
- tx_valid=0, rx_ready=0, retired=0, halted=0, halt_code=0, phase_exec=0.

States:
- FETCH (1 cycle): capture instr into IR; go to EXEC.
- EXEC (1 cycle): evaluate cond against current flags.
  - cond codes: 0 always, 1 C, 2 Z, 3 N, 4 O, 5 !C, 6 !Z, 7 never.
  - cond false: no register, flag or I/O effect; pc+1; retired=1; go to FETCH.
- Normal instruction = 2 cycles; retired pulses on the EXEC→FETCH edge, or WAIT→FETCH for I/O.

Ops (cond true):
- 0 NOP.
- 1 LDI: R[rd]=imm; flags unchanged.
- 2 ADD: R[rd]=R[rd]+R[rs]; C=carry out; O=signed overflow.
- 3 SUB: R[rd]=R[rd]-R[rs]; C=borrow (R[rd]<R[rs] unsigned); O=signed overflow.
- ADD/SUB set Z=(result==0) and N=result MSB.
- 4 OUT: go to WAIT_TX; tx_valid=1, tx_data=R[rs] held stable.
  - Leave WAIT_TX on the first cycle with tx_ready=1 sampled while tx_valid=1; tx_valid=0 next cycle.
- 5 IN: go to WAIT_RX; rx_ready=1.
  - On the cycle rx_valid=1: R[rd]=rx_data, rx_ready=0 next cycle.
  - Neither I/O op changes flags.
- 6 JMP: pc={R[rs],imm}[AWIDTH-1:0], taking the low AWIDTH bits of the concatenation.
- 7 HALT: halt_code=R[rs]; halted=1; state=HALTED.
  - HALTED is absorbing until MR; pc frozen; no further retired pulses.

Rules:
- pc increments modulo 2^AWIDTH for all ops except a taken JMP; 2^AWIDTH-1 wraps to 0.
- Register writes and flag updates happen on the edge ending EXEC, or ending WAIT for IN.
- A read of R[rd] in the same instruction sees the pre-write value.
- WAIT states have no timeout. The handshake signals must reach 0 within one cycle of MR asserting, even mid-transfer.
- After MR deasserts, the first FETCH is from address 0.
- rx_valid or tx_ready asserted outside WAIT has no effect.
- X on instr during FETCH is a simulation error: $error, then $finish.

Test Plan:
- Reset/wrap: MR mid-run with AWIDTH=4 → pc=0, flags=0. Program of 16 NOPs → pc wraps 15→0, retired pulses every 2 cycles.
- Arithmetic (DWIDTH=8):
  - LDI R0=0x7F, LDI R1=0x01, ADD R0,R1 → R0=0x80, flags C=0,Z=0,N=1,O=1.
  - SUB R1,R1 → R1=0, Z=1, C=0.
  - LDI R2=0x00, SUB R2,R3 (R3=1) → R2=0xFF, C=1, N=1.
- Condition gating: with Z=1, "cond=!Z ADD R0,R0" → R0 and flags unchanged, pc+1, retired=1. "cond=Z JMP R1:0x10" (R1=0) → pc=0x0010.
- TX handshake: OUT R0 (R0=0x41), tx_ready held 0 for 5 cycles → tx_valid=1 and tx_data=0x41 stable for those cycles, pc unchanged. tx_ready=1 → single accept, next FETCH at pc+1.
- RX handshake: IN R3 with rx_valid rising after 3 cycles, rx_data=0x5A → R3=0x5A, rx_ready drops the cycle after the transfer.
- Halt: LDI R2=0x2A; HALT rs=R2 → halted=1, halt_code=0x2A, pc frozen ≥10 cycles, no retired pulses. MR → halted=0, pc=0.
